// File: rtl/sm_scan_decoder.sv
// Rebuilds the four digits shown on a multiplexed 7-segment scan bus as BCD codes.
// Also reports decimal points, per-digit glyph legality, frame completion, scan stalls and multi-enable errors.
module sm_scan_decoder #(
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit WEI_ACT_LOW = 1'b1,
  parameter int SETTLE_CYC  = 16,
  parameter int STALL_CYC   = 200000
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic [7:0]  sm_duan,
  input  logic [3:0]  sm_wei,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        scan_stall,
  output logic        err_multi
);

  localparam int CNT_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int STALL_W = $clog2(STALL_CYC + 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(STALL_CYC);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  // Returns {valid, code}; unknown glyphs map to E and are flagged invalid.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'h3F:   decode_glyph = {1'b1, 4'h0};
      7'h06:   decode_glyph = {1'b1, 4'h1};
      7'h5B:   decode_glyph = {1'b1, 4'h2};
      7'h4F:   decode_glyph = {1'b1, 4'h3};
      7'h66:   decode_glyph = {1'b1, 4'h4};
      7'h6D:   decode_glyph = {1'b1, 4'h5};
      7'h7D:   decode_glyph = {1'b1, 4'h6};
      7'h07:   decode_glyph = {1'b1, 4'h7};
      7'h7F:   decode_glyph = {1'b1, 4'h8};
      7'h6F:   decode_glyph = {1'b1, 4'h9};
      7'h00:   decode_glyph = {1'b1, 4'hF};
      default: decode_glyph = {1'b0, 4'hE};
    endcase
  endfunction

  logic [7:0]         seg_q, seg_qq;
  logic [3:0]         wei_q, wei_qq;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         seen;
  logic [STALL_W-1:0] stall_cnt;

  logic       wei_onehot, wei_multi, same, capture;
  logic [1:0] sel;
  logic [3:0] seen_nxt;
  logic [4:0] dec;

  // Input stage: segment data is free-running, enables are reset so the FSM starts in IDLE.
  always_ff @(posedge clk_50MHz) begin
    seg_q  <= SEG_ACT_LOW ? ~sm_duan : sm_duan;
    seg_qq <= seg_q;
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      wei_q  <= 4'h0;
      wei_qq <= 4'h0;
    end else begin
      wei_q  <= WEI_ACT_LOW ? ~sm_wei : sm_wei;
      wei_qq <= wei_q;
    end
  end

  always_comb begin
    wei_onehot = (wei_q != 4'h0) && ((wei_q & (wei_q - 4'd1)) == 4'h0);
    wei_multi  = (wei_q != 4'h0) && !wei_onehot;
    same       = ({seg_q, wei_q} == {seg_qq, wei_qq});
    capture    = wei_onehot && same && (state == SETTLE) && (cnt == SETTLE_LAST);
    dec        = decode_glyph(seg_q[6:0]);
    case (wei_q)
      4'b0010: sel = 2'd1;
      4'b0100: sel = 2'd2;
      4'b1000: sel = 2'd3;
      default: sel = 2'd0;
    endcase
    seen_nxt = seen | (4'b0001 << sel);
  end

  // Capture stage: settle FSM, digit slots, frame tracking and stall counter.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      seen        <= 4'h0;
      stall_cnt   <= '0;
      frame_done  <= 1'b0;
      err_multi   <= 1'b0;
      digits      <= 16'hFFFF;
      dp          <= 4'h0;
      digit_valid <= 4'h0;
    end else begin
      frame_done <= 1'b0;
      if (wei_multi) err_multi <= 1'b1;

      if (!wei_onehot) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (!same) begin
        state <= SETTLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= SETTLE;
            cnt   <= '0;
          end
          SETTLE: begin
            if (cnt == SETTLE_LAST) state <= HELD;
            else                    cnt   <= cnt + 1'b1;
          end
          default: state <= HELD;
        endcase
      end

      if (capture) begin
        digits[{sel, 2'b00} +: 4] <= dec[3:0];
        dp[sel]                   <= seg_q[7];
        digit_valid[sel]          <= dec[4];
        stall_cnt                 <= '0;
        if (seen_nxt == 4'hF) begin
          seen       <= 4'h0;
          frame_done <= 1'b1;
        end else begin
          seen <= seen_nxt;
        end
      end else if (stall_cnt != STALL_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign scan_stall = (stall_cnt == STALL_MAX);

endmodule

// File: tb/tb_sm_scan_decoder.sv
// Directed bench for sm_scan_decoder: table of single-digit glyph captures plus
// hand-written sequences for ghosting, latency, multi-enable, stall and mid-frame reset.
module tb_sm_scan_decoder;

  logic        clk_50MHz = 1'b0;
  logic        reset;
  logic [7:0]  sm_duan;
  logic [3:0]  sm_wei;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        scan_stall;
  logic        err_multi;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;

  sm_scan_decoder #(
    .SEG_ACT_LOW(1'b1),
    .WEI_ACT_LOW(1'b1),
    .SETTLE_CYC (4),
    .STALL_CYC  (100)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .reset      (reset),
    .sm_duan    (sm_duan),
    .sm_wei     (sm_wei),
    .digits     (digits),
    .dp         (dp),
    .digit_valid(digit_valid),
    .frame_done (frame_done),
    .scan_stall (scan_stall),
    .err_multi  (err_multi)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(negedge clk_50MHz) if (frame_done) frame_cnt++;

  typedef struct {
    int         dig;
    logic [6:0] glyph;
    logic       dpb;
    logic [3:0] code;
    logic       valid;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives the active-low pattern and holds it for n cycles.
  task automatic show(input int d, input logic [6:0] g, input logic p, input int n);
    logic [3:0] w;
    w = 4'b0001 << d;
    sm_duan = ~{p, g};
    sm_wei  = ~w;
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic scan_1234();
    show(0, 7'h66, 1'b0, 50);
    show(1, 7'h4F, 1'b0, 50);
    show(2, 7'h5B, 1'b0, 50);
    show(3, 7'h06, 1'b0, 50);
  endtask

  logic [15:0] exp_d;
  logic [3:0]  exp_dp, exp_v;
  int          fc;

  initial begin
    vecs[0]  = '{0, 7'h3F, 1'b0, 4'h0, 1'b1};
    vecs[1]  = '{1, 7'h06, 1'b1, 4'h1, 1'b1};
    vecs[2]  = '{2, 7'h5B, 1'b0, 4'h2, 1'b1};
    vecs[3]  = '{3, 7'h4F, 1'b0, 4'h3, 1'b1};
    vecs[4]  = '{0, 7'h66, 1'b0, 4'h4, 1'b1};
    vecs[5]  = '{1, 7'h6D, 1'b0, 4'h5, 1'b1};
    vecs[6]  = '{2, 7'h7D, 1'b1, 4'h6, 1'b1};
    vecs[7]  = '{3, 7'h07, 1'b0, 4'h7, 1'b1};
    vecs[8]  = '{0, 7'h7F, 1'b0, 4'h8, 1'b1};
    vecs[9]  = '{1, 7'h6F, 1'b0, 4'h9, 1'b1};
    vecs[10] = '{2, 7'h00, 1'b0, 4'hF, 1'b1};
    vecs[11] = '{1, 7'h49, 1'b1, 4'hE, 1'b0};
    vecs[12] = '{3, 7'h7E, 1'b0, 4'hE, 1'b0};

    reset   = 1'b0;
    sm_duan = 8'hFF;
    sm_wei  = 4'hF;
    repeat (3) @(negedge clk_50MHz);
    check("reset_digits", 32'(digits), 32'hFFFF);
    check("reset_dp", 32'(dp), 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);
    check("reset_frame", 32'(frame_done), 32'h0);
    check("reset_stall", 32'(scan_stall), 32'h0);
    check("reset_err", 32'(err_multi), 32'h0);
    reset = 1'b1;
    @(negedge clk_50MHz);

    // Two full scans of "1234": one frame each.
    fc = frame_cnt;
    scan_1234();
    check("scan_frame1", 32'(frame_cnt - fc), 32'd1);
    scan_1234();
    check("scan_digits", 32'(digits), 32'h1234);
    check("scan_valid", 32'(digit_valid), 32'hF);
    check("scan_dp", 32'(dp), 32'h0);
    check("scan_frame2", 32'(frame_cnt - fc), 32'd2);

    // Ghost on digit 2 for 3 cycles must be rejected.
    fc = frame_cnt;
    show(0, 7'h66, 1'b0, 20);
    show(2, 7'h7F, 1'b0, 3);
    show(0, 7'h66, 1'b0, 30);
    check("ghost_digits", 32'(digits), 32'h1234);
    check("ghost_frame", 32'(frame_cnt - fc), 32'd0);

    // Latency: visible only after edge N+SETTLE_CYC+1.
    show(3, 7'h07, 1'b0, 5);
    check("latency_early", 32'(digits[15:12]), 32'h1);
    @(negedge clk_50MHz);
    check("latency_ontime", 32'(digits[15:12]), 32'h7);
    repeat (20) @(negedge clk_50MHz);

    exp_d  = 16'h7234;
    exp_dp = 4'h0;
    exp_v  = 4'hF;
    for (int i = 0; i < 13; i++) begin
      show(vecs[i].dig, vecs[i].glyph, vecs[i].dpb, 50);
      exp_d[4*vecs[i].dig +: 4] = vecs[i].code;
      exp_dp[vecs[i].dig]       = vecs[i].dpb;
      exp_v[vecs[i].dig]        = vecs[i].valid;
      check($sformatf("vec%0d_digits", i), 32'(digits), 32'(exp_d));
      check($sformatf("vec%0d_dp", i), 32'(dp), 32'(exp_dp));
      check($sformatf("vec%0d_valid", i), 32'(digit_valid), 32'(exp_v));
    end
    check("no_err_before_multi", 32'(err_multi), 32'h0);

    // Two enables active for one cycle.
    sm_duan = ~8'h06;
    sm_wei  = 4'b0011;
    @(negedge clk_50MHz);
    sm_wei = 4'hF;
    repeat (2) @(negedge clk_50MHz);
    check("err_multi_set", 32'(err_multi), 32'h1);
    repeat (20) @(negedge clk_50MHz);
    check("err_multi_sticky", 32'(err_multi), 32'h1);

    // Stall: freeze on all-off enables, then resume.
    show(0, 7'h3F, 1'b0, 50);
    check("stall_active_scan", 32'(scan_stall), 32'h0);
    sm_wei = 4'hF;
    repeat (40) @(negedge clk_50MHz);
    check("stall_not_yet", 32'(scan_stall), 32'h0);
    repeat (80) @(negedge clk_50MHz);
    check("stall_set", 32'(scan_stall), 32'h1);
    show(1, 7'h06, 1'b0, 3);
    check("stall_before_capture", 32'(scan_stall), 32'h1);
    show(1, 7'h06, 1'b0, 47);
    check("stall_cleared", 32'(scan_stall), 32'h0);
    check("err_multi_still", 32'(err_multi), 32'h1);

    // Reset mid-frame after 3 captures discards the partial frame.
    show(0, 7'h3F, 1'b0, 50);
    show(1, 7'h06, 1'b0, 50);
    show(2, 7'h5B, 1'b0, 50);
    fc = frame_cnt;
    reset  = 1'b0;
    sm_wei = 4'hF;
    #5;
    check("midreset_digits", 32'(digits), 32'hFFFF);
    check("midreset_err", 32'(err_multi), 32'h0);
    check("midreset_valid", 32'(digit_valid), 32'h0);
    #15;
    reset = 1'b1;
    @(negedge clk_50MHz);
    show(3, 7'h6D, 1'b0, 50);
    check("midreset_no_frame", 32'(frame_cnt - fc), 32'd0);
    show(0, 7'h7D, 1'b0, 50);
    show(1, 7'h7F, 1'b0, 50);
    check("midreset_partial", 32'(frame_cnt - fc), 32'd0);
    show(2, 7'h6F, 1'b0, 50);
    check("midreset_frame", 32'(frame_cnt - fc), 32'd1);
    check("midreset_final_digits", 32'(digits), 32'h5986);
    check("midreset_final_valid", 32'(digit_valid), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
